// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXECUTE/WRITEBACK per instruction, internal
// register file, synchronous external program memory, halt on opcode 0x3F.
module mips_multicycle_core #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 8,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic [31:0]       imem_data_i,
    output logic              busy_o,
    output logic              halted_o,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);
    localparam int unsigned RegCount = 2 ** REG_AW;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpHalt  = 6'h3F;

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnXor = 6'h26;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StHalt
    } state_e;

    state_e state_q, state_d;

    logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
    // rs is consumed into a_q at DECODE, so the IR keeps opcode plus bits [20:0] only
    logic [26:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] result_q;
    logic              result_valid_q;
    logic [DATA_W-1:0] rf_q [RegCount];

    logic [5:0]        opcode, funct;
    logic [4:0]        shamt;
    logic [REG_AW-1:0] rt, rd, dec_rs, dec_rt;
    logic [31:0]       simm32, zimm32, shamt32;
    logic [DATA_W-1:0] simm, zimm;

    assign opcode  = ir_q[26:21];
    assign rt      = ir_q[16 +: REG_AW];
    assign rd      = ir_q[11 +: REG_AW];
    assign shamt   = ir_q[10:6];
    assign funct   = ir_q[5:0];
    assign simm32  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign zimm32  = {16'h0000, ir_q[15:0]};
    assign simm    = simm32[DATA_W-1:0];
    assign zimm    = zimm32[DATA_W-1:0];
    assign shamt32 = {27'd0, shamt};
    assign dec_rs  = imem_data_i[21 +: REG_AW];
    assign dec_rt  = imem_data_i[16 +: REG_AW];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StHalt: if (start_i) state_d = StFetch;
            StFetch:        state_d = StDecode;
            StDecode:       state_d = (imem_data_i[31:26] == OpHalt) ? StHalt : StExecute;
            StExecute:      state_d = StWriteback;
            StWriteback:    state_d = StFetch;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        alu_d     = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = rt;
        case (opcode)
            OpRtype: begin
                wr_addr_d = rd;
                wr_en_d   = 1'b1;
                case (funct)
                    FnAdd:   alu_d = a_q + b_q;
                    FnSub:   alu_d = a_q - b_q;
                    FnAnd:   alu_d = a_q & b_q;
                    FnOr:    alu_d = a_q | b_q;
                    FnXor:   alu_d = a_q ^ b_q;
                    FnSlt:   alu_d = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                    FnSll:   alu_d = (shamt32 >= DATA_W) ? '0 : (b_q << shamt);
                    default: wr_en_d = 1'b0;
                endcase
            end
            OpAddi: begin
                alu_d   = a_q + simm;
                wr_en_d = 1'b1;
            end
            OpAndi: begin
                alu_d   = a_q & zimm;
                wr_en_d = 1'b1;
            end
            OpOri: begin
                alu_d   = a_q | zimm;
                wr_en_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch offset truncated to PC_W bits gives the modulo-2^PC_W target directly
    always_comb begin
        pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        pc_d   = pc_inc;
        case (opcode)
            OpBeq:   if (a_q == b_q) pc_d = pc_inc + simm32[PC_W-1:0];
            OpBne:   if (a_q != b_q) pc_d = pc_inc + simm32[PC_W-1:0];
            OpJ:     pc_d = ir_q[PC_W-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pc_q           <= '0;
            ir_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            alu_q          <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            for (int unsigned i = 0; i < RegCount; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                StIdle, StHalt: if (start_i) pc_q <= '0;
                StDecode: begin
                    ir_q <= {imem_data_i[31:26], imem_data_i[20:0]};
                    a_q  <= rf_q[dec_rs];
                    b_q  <= rf_q[dec_rt];
                end
                StExecute: begin
                    alu_q     <= alu_d;
                    wr_en_q   <= wr_en_d;
                    wr_addr_q <= wr_addr_d;
                end
                StWriteback: begin
                    pc_q <= pc_d;
                    if (wr_en_q && (wr_addr_q != '0)) begin
                        rf_q[wr_addr_q] <= alu_q;
                        result_q        <= alu_q;
                        result_valid_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr_o    = pc_q;
    assign busy_o         = (state_q != StIdle) && (state_q != StHalt);
    assign halted_o       = (state_q == StHalt);
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign dbg_data_o     = (dbg_addr_i == '0) ? '0 : rf_q[dbg_addr_i];

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: directed programs plus random programs
// checked against an instruction-level interpreter.
module tb_mips_multicycle_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start4;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data, result, dbg_data;
    logic        busy, halted, result_valid;
    logic [4:0]  dbg_addr;

    logic [3:0]  imem4_addr;
    logic [31:0] imem4_data, result4, dbg4_data;
    logic        busy4, halted4, result_valid4;
    logic [4:0]  dbg4_addr;

    logic [31:0] mem [256];
    logic [31:0] mem4 [16];

    always @(posedge clk) imem_data <= mem[imem_addr];
    always @(posedge clk) imem4_data <= mem4[imem4_addr];

    mips_multicycle_core #(.DATA_W(32), .PC_W(8), .REG_AW(5)) dut (
        .clock_i(clk), .reset_i(reset), .start_i(start),
        .imem_addr_o(imem_addr), .imem_data_i(imem_data),
        .busy_o(busy), .halted_o(halted),
        .result_o(result), .result_valid_o(result_valid),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
    );

    mips_multicycle_core #(.DATA_W(32), .PC_W(4), .REG_AW(5)) dut4 (
        .clock_i(clk), .reset_i(reset), .start_i(start4),
        .imem_addr_o(imem4_addr), .imem_data_i(imem4_data),
        .busy_o(busy4), .halted_o(halted4),
        .result_o(result4), .result_valid_o(result_valid4),
        .dbg_addr_i(dbg4_addr), .dbg_data_o(dbg4_data)
    );

    localparam logic [31:0] HALT = 32'hFC00_0000;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] mregs [32];
    int mcycles;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = HALT;
        foreach (mem4[i]) mem4[i] = HALT;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Pulse start, then count edges after the sampling edge until halted (bounded)
    task automatic run_dut(input int max_cycles, output int cycles);
        obs_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (!halted && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
            if (result_valid) obs_q.push_back(result);
        end
    endtask

    // Instruction-set interpreter over mem[]: expected writes, final registers, cycle count
    task automatic model_run(input bit clear_regs);
        logic [7:0]  pc;
        logic [31:0] ins, v, sx;
        logic [4:0]  rs, rt, rd, dst;
        logic [5:0]  op, fn;
        bit          wr;
        if (clear_regs) foreach (mregs[i]) mregs[i] = 32'd0;
        exp_q.delete();
        mcycles = 0;
        pc = 8'd0;
        for (int steps = 0; steps < 2000; steps++) begin
            ins = mem[pc];
            op = ins[31:26];
            if (op == 6'h3F) begin
                mcycles += 2;
                return;
            end
            mcycles += 4;
            rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
            sx = {{16{ins[15]}}, ins[15:0]};
            wr = 1'b0; v = 32'd0; dst = rt;
            case (op)
                6'h00: begin
                    dst = rd;
                    wr = 1'b1;
                    case (fn)
                        6'h20: v = mregs[rs] + mregs[rt];
                        6'h22: v = mregs[rs] - mregs[rt];
                        6'h24: v = mregs[rs] & mregs[rt];
                        6'h25: v = mregs[rs] | mregs[rt];
                        6'h26: v = mregs[rs] ^ mregs[rt];
                        6'h2A: v = ($signed(mregs[rs]) < $signed(mregs[rt])) ? 32'd1 : 32'd0;
                        6'h00: v = mregs[rt] << ins[10:6];
                        default: wr = 1'b0;
                    endcase
                end
                6'h08: begin v = mregs[rs] + sx; wr = 1'b1; end
                6'h0C: begin v = mregs[rs] & {16'h0, ins[15:0]}; wr = 1'b1; end
                6'h0D: begin v = mregs[rs] | {16'h0, ins[15:0]}; wr = 1'b1; end
                default: ;
            endcase
            if ((op == 6'h04 && mregs[rs] == mregs[rt]) || (op == 6'h05 && mregs[rs] != mregs[rt]))
                pc = pc + 8'd1 + sx[7:0];
            else if (op == 6'h02)
                pc = ins[7:0];
            else
                pc = pc + 8'd1;
            if (wr && dst != 5'd0) begin
                mregs[dst] = v;
                exp_q.push_back(v);
            end
        end
        mcycles = -1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({busy, halted, result_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000", {busy, halted, result_valid});
        end
        tests_run++;
        if (result !== 32'd0 || imem_addr !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_result_addr: got %h/%h expected 0/0", result, imem_addr);
        end
        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r);
            #1;
            tests_run++;
            if (dbg_data !== 32'd0) begin
                tests_failed++;
                $display("FAIL reset_reg%0d: got %h expected 0", r, dbg_data);
            end
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || imem_addr !== 8'd0 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_stays: got busy=%b addr=%h halted=%b expected 0/0/0",
                     busy, imem_addr, halted);
        end
    endtask

    task automatic test_program();
        logic [31:0] want [3];
        logic [31:0] got;
        int cyc;
        want[0] = 32'd5; want[1] = 32'hFFFF_FFFD; want[2] = 32'd2;
        clear_mem();
        mem[0] = enc_i(8, 0, 1, 5);
        mem[1] = enc_i(8, 0, 2, -3);
        mem[2] = enc_r(1, 2, 3, 0, 'h20);
        do_reset();
        run_dut(100, cyc);
        tests_run++;
        if (cyc !== 14) begin
            tests_failed++;
            $display("FAIL prog_halt_cycles: got %0d expected 14", cyc);
        end
        tests_run++;
        if (obs_q.size() !== 3) begin
            tests_failed++;
            $display("FAIL prog_write_count: got %0d expected 3", obs_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 32'hxxxx_xxxx;
            tests_run++;
            if (got !== want[i]) begin
                tests_failed++;
                $display("FAIL prog_write%0d: got %h expected %h", i, got, want[i]);
            end
        end
        dbg_addr = 5'd3;
        #1;
        tests_run++;
        if (dbg_data !== 32'd2 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL prog_dbg3: got %h busy=%b expected 2 busy=0", dbg_data, busy);
        end
    endtask

    task automatic test_alu_corners();
        int regs [5];
        logic [31:0] want [5];
        int cyc;
        regs[0] = 2; want[0] = 32'hFFFF_FFFF;
        regs[1] = 4; want[1] = 32'd1;
        regs[2] = 5; want[2] = 32'h8000_0000;
        regs[3] = 6; want[3] = 32'h0000_FFFF;
        regs[4] = 7; want[4] = 32'h8000_FFFF;
        clear_mem();
        mem[0] = enc_i(8, 0, 1, 1);
        mem[1] = enc_r(0, 1, 2, 0, 'h22);
        mem[2] = enc_i(8, 0, 3, -1);
        mem[3] = enc_r(3, 1, 4, 0, 'h2A);
        mem[4] = enc_r(0, 1, 5, 31, 'h00);
        mem[5] = enc_i('h0C, 3, 6, 'hFFFF);
        mem[6] = enc_r(5, 6, 7, 0, 'h26);
        do_reset();
        run_dut(200, cyc);
        for (int i = 0; i < 5; i++) begin
            dbg_addr = 5'(regs[i]);
            #1;
            tests_run++;
            if (dbg_data !== want[i]) begin
                tests_failed++;
                $display("FAIL alu_reg%0d: got %h expected %h", regs[i], dbg_data, want[i]);
            end
        end
    endtask

    task automatic test_loop();
        logic [31:0] want [7];
        logic [31:0] got;
        int cyc;
        want = '{32'd3, 32'd2, 32'd1, 32'd1, 32'd2, 32'd0, 32'd3};
        clear_mem();
        mem[0] = enc_i(8, 0, 1, 3);
        mem[1] = enc_i(8, 1, 1, -1);
        mem[2] = enc_i(8, 2, 2, 1);
        mem[3] = enc_i(5, 1, 0, -3);
        do_reset();
        run_dut(200, cyc);
        tests_run++;
        if (cyc !== 42 || obs_q.size() !== 7) begin
            tests_failed++;
            $display("FAIL loop_shape: got cycles=%0d writes=%0d expected 42/7", cyc, obs_q.size());
        end
        for (int i = 0; i < 7; i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 32'hxxxx_xxxx;
            tests_run++;
            if (got !== want[i]) begin
                tests_failed++;
                $display("FAIL loop_write%0d: got %h expected %h", i, got, want[i]);
            end
        end
        dbg_addr = 5'd2;
        #1;
        tests_run++;
        if (dbg_data !== 32'd3) begin
            tests_failed++;
            $display("FAIL loop_iterations: got %h expected 3", dbg_data);
        end
    endtask

    task automatic test_jump();
        clear_mem();
        mem[0] = enc_j('h10);
        do_reset();
        mem[16] = HALT;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (imem_addr !== 8'h00 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL jump_first_fetch: got addr=%h busy=%b expected 00/1", imem_addr, busy);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (imem_addr !== 8'h10) begin
            tests_failed++;
            $display("FAIL jump_target: got %h expected 10", imem_addr);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (halted !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL jump_halt: got halted=%b busy=%b expected 1/0", halted, busy);
        end
    endtask

    task automatic test_r0_nop();
        int cyc;
        clear_mem();
        mem[0] = enc_i(8, 0, 1, 7);
        mem[1] = enc_r(1, 1, 0, 0, 'h20);
        mem[2] = enc_i('h3E, 1, 1, 'h1234);
        mem[3] = enc_r(1, 1, 4, 0, 'h3F);
        mem[4] = enc_i(8, 0, 2, 9);
        do_reset();
        run_dut(200, cyc);
        tests_run++;
        if (cyc !== 22) begin
            tests_failed++;
            $display("FAIL nop_cycles: got %0d expected 22", cyc);
        end
        tests_run++;
        if (obs_q.size() !== 2 || (obs_q.size() == 2 && (obs_q[0] !== 32'd7 || obs_q[1] !== 32'd9)))
        begin
            tests_failed++;
            $display("FAIL nop_writes: got %0d writes expected 2 (7, 9)", obs_q.size());
        end
        dbg_addr = 5'd0;
        #1;
        tests_run++;
        if (dbg_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL r0_read: got %h expected 0", dbg_data);
        end
        dbg_addr = 5'd4;
        #1;
        tests_run++;
        if (dbg_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL nop_funct_reg4: got %h expected 0", dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        clear_mem();
        mem[0] = enc_i(8, 1, 1, 1);
        do_reset();
        for (int pass = 1; pass <= 2; pass++) begin
            run_dut(100, cyc);
            tests_run++;
            if (cyc !== 6 || obs_q.size() !== 1 || (obs_q.size() == 1 && obs_q[0] !== 32'(pass)))
            begin
                tests_failed++;
                $display("FAIL restart_pass%0d: got cycles=%0d result=%h expected 6/%0d",
                         pass, cyc, result, pass);
            end
        end
    endtask

    task automatic test_reset_midrun();
        clear_mem();
        mem[0] = enc_i(8, 0, 1, 5);
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrun_busy: got %b expected 1", busy);
        end
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        dbg_addr = 5'd1;
        #1;
        tests_run++;
        if ({busy, halted, result_valid} !== 3'b000 || result !== 32'd0 || dbg_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL midrun_abort: got flags=%b result=%h reg1=%h expected 000/0/0",
                     {busy, halted, result_valid}, result, dbg_data);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || imem_addr !== 8'd0 || dbg_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL midrun_idle: got busy=%b addr=%h reg1=%h expected 0/00/0",
                     busy, imem_addr, dbg_data);
        end
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        mem4[0]  = enc_i(5, 1, 0, 1);
        mem4[1]  = enc_j(15);
        mem4[15] = enc_i(8, 0, 1, 1);
        do_reset();
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (8) @(negedge clk);
        tests_run++;
        if (imem4_addr !== 4'hF) begin
            tests_failed++;
            $display("FAIL wrap_at15: got %h expected f", imem4_addr);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (imem4_addr !== 4'h0 || result_valid4 !== 1'b1 || result4 !== 32'd1) begin
            tests_failed++;
            $display("FAIL wrap_to0: got addr=%h rv=%b result=%h expected 0/1/1",
                     imem4_addr, result_valid4, result4);
        end
        repeat (6) @(negedge clk);
        dbg4_addr = 5'd1;
        #1;
        tests_run++;
        if (halted4 !== 1'b1 || dbg4_data !== 32'd1) begin
            tests_failed++;
            $display("FAIL wrap_halt: got halted=%b reg1=%h expected 1/1", halted4, dbg4_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        int len, kind, rs, rt, rd, cyc;
        int fns [8];
        fns = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h2A, 'h00, 'h3F};
        for (int prog = 0; prog < 20; prog++) begin
            clear_mem();
            len = $urandom_range(10, 16);
            for (int p = 0; p < len; p++) begin
                kind = $urandom_range(0, 9);
                rs = $urandom_range(0, 7);
                rt = $urandom_range(0, 7);
                rd = $urandom_range(0, 7);
                case (kind)
                    0, 1, 2, 3: mem[p] = enc_r(rs, rt, rd, $urandom_range(0, 31),
                                               fns[$urandom_range(0, 7)]);
                    4, 5:       mem[p] = enc_i(8, rs, rt, $urandom_range(0, 65535));
                    6:          mem[p] = enc_i('h0C, rs, rt, $urandom_range(0, 65535));
                    7:          mem[p] = enc_i('h0D, rs, rt, $urandom_range(0, 65535));
                    8:          mem[p] = enc_i($urandom_range(4, 5), rs, rt, $urandom_range(0, 3));
                    default:    mem[p] = enc_i('h10 + $urandom_range(0, 15), rs, rt, 'hBEEF);
                endcase
            end
            do_reset();
            model_run(1'b1);
            run_dut(2000, cyc);
            tests_run++;
            if (cyc !== mcycles || obs_q.size() !== exp_q.size()) begin
                tests_failed++;
                $display("FAIL rand%0d_shape: got cycles=%0d writes=%0d expected %0d/%0d",
                         prog, cyc, obs_q.size(), mcycles, exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                got = (i < obs_q.size()) ? obs_q[i] : 32'hxxxx_xxxx;
                tests_run++;
                if (got !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_write%0d: got %h expected %h", prog, i, got, exp_q[i]);
                end
            end
            for (int r = 1; r < 8; r++) begin
                dbg_addr = 5'(r);
                #1;
                tests_run++;
                if (dbg_data !== mregs[r]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_reg%0d: got %h expected %h", prog, r, dbg_data, mregs[r]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        dbg_addr = 5'd0;
        dbg4_addr = 5'd0;
        clear_mem();
        test_reset();
        test_program();
        test_alu_corners();
        test_loop();
        test_jump();
        test_r0_nop();
        test_back_to_back();
        test_reset_midrun();
        test_pc_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multicycle successor to the single-path MIPS datapath: fetches instructions from an external synchronous program memory, decodes them, executes them on an internal ALU and writes results back into an internal register file. PC, data width and register count are parametrised. Adds register write-back, branches, jumps, halt and a run/halt handshake. It sits between the program memory and the board-level result display and debug logic.

## Interface
- DATA_W, 32: datapath and register width; legal range 16..32.
- PC_W, 8: program counter width in words; memory depth is 2^PC_W.
- REG_AW, 5: register address width; REG_COUNT = 2^REG_AW, legal range 3..5. Uses the low REG_AW bits of the rs/rt/rd fields.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins execution at PC 0 from IDLE or HALT.
- imem_addr  out  PC_W  word address to program memory; equals the PC register.
- imem_data  in  32  instruction word, valid one cycle after imem_addr is sampled.
- busy  out  1  high from the cycle after start until halt.
- halted  out  1  high while in HALT.
- result  out  DATA_W  last value written to the register file.
- result_valid  out  1  one-cycle pulse per register write.
- dbg_addr  in  REG_AW  debug register select.
- dbg_data  out  DATA_W  combinational read of register dbg_addr.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- Transitions:
  - IDLE --start--> FETCH, with PC cleared to 0.
  - FETCH -> DECODE. Memory samples imem_addr in this cycle.
  - DECODE: latch IR from imem_data and read rs/rt into A/B.
  - DECODE -> HALT on opcode 0x3F; otherwise -> EXECUTE.
  - EXECUTE -> WRITEBACK.
  - WRITEBACK -> FETCH.
  - HALT --start--> FETCH, with PC cleared to 0. Registers are retained.
- start is ignored in every other state.
- R-type (opcode 0x00), by funct:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor.
  - 0x2A slt: signed compare, result 1 or 0.
  - 0x00 sll: rt shifted by shamt; shamt >= DATA_W gives 0.
  - Destination is rd.
- I-type:
  - 0x08 addi: sign-extended immediate.
  - 0x0C andi and 0x0D ori: zero-extended immediate.
  - Destination is rt.
- Branches: 0x04 beq and 0x05 bne. Target = PC+1+sign-extended offset, modulo 2^PC_W.
- 0x02 j: PC = target[PC_W-1:0].
- Any other opcode or funct executes as a NOP. PC advances and nothing is written.
- Arithmetic wraps modulo 2^DATA_W. No overflow trap. Immediates are truncated to DATA_W.
- Register 0 always reads 0. Writes to register 0 are discarded, and result_valid is not asserted for them.
- PC increments modulo 2^PC_W: 2^PC_W-1 wraps to 0.
- Reset from any state:
  - Enter IDLE with PC=0 and all registers 0.
  - busy=0, halted=0, result=0, result_valid=0.
  - Any in-flight write is aborted. Reset takes priority over start in the same cycle.

## Timing
- Every instruction takes 4 cycles: FETCH, DECODE, EXECUTE, WRITEBACK.
- HALT is entered after 2 cycles (FETCH, DECODE).
- The register write occurs on the WRITEBACK edge.
- result and result_valid are registered and appear the cycle after WRITEBACK, together with the updated dbg_data.
- The new PC is visible on imem_addr during the next FETCH.
- A write followed by a read of the same register in the next instruction sees the new value. No forwarding is needed, because DECODE occurs two or more cycles after WRITEBACK.
- busy rises in the cycle after start is sampled. halted rises and busy falls in the cycle after the halting DECODE.

## Test plan
- Reset then idle: all outputs 0, imem_addr=0; with no start the core stays in IDLE and imem_addr stays 0.
- Program "addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; halt":
  - result_valid pulses 3 times with results 5, 0xFFFFFFFD, 2.
  - halted rises 14 cycles after start.
  - dbg_addr=3 reads 2.
- ALU corners:
  - sub 0-1 gives 0xFFFFFFFF.
  - slt -1<1 gives 1.
  - sll by 31 of 1 gives 0x80000000.
  - andi with 0xFFFF gives zero-extended 0x0000FFFF.
- Control flow: a bne loop decrementing $1 from 3 to 0 runs exactly 3 iterations. j to address 0x10 shows imem_addr=0x10 in the next FETCH. With PC_W=4, execution at PC 15 wraps to 0.
- Register 0 and NOP: add $0,$1,$1 gives no result_valid and dbg read of register 0 stays 0. An undefined opcode advances PC with no write.
- Reset mid-run: assert reset during WRITEBACK of an addi → no write occurs, registers read 0, state IDLE. start in the same cycle as reset is ignored.
